// File: rtl/mem_port_arbiter.sv
// Two-lane memory-stage arbiter: serialises the lane requests onto one data-memory port, lane 0 first.
// Optional bus-ack watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int DATA_W         = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flash,
  input  logic [1:0]             lane_valid,
  input  logic [1:0]             lane_we,
  input  logic [1:0][3:0]        lane_be,
  input  logic [1:0][31:0]       lane_addr,
  input  logic [1:0][DATA_W-1:0] lane_wdata,
  output logic                   stall_req,
  output logic [1:0][DATA_W-1:0] lane_rdata,
  output logic                   done,
  output logic                   bus_req,
  output logic                   bus_we,
  output logic [3:0]             bus_be,
  output logic [31:0]            bus_addr,
  output logic [DATA_W-1:0]      bus_wdata,
  input  logic                   bus_ack,
  input  logic [DATA_W-1:0]      bus_rdata,
  output logic [1:0]             lane_err
);

  typedef enum logic [1:0] {IDLE, L0, L1, DONE} state_t;

  typedef struct packed {
    logic              we;
    logic [3:0]        be;
    logic [31:0]       addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  state_t                   r_state, w_next;
  req_t   [1:0]             r_req;
  logic                     r_v1;      // lane 0 valid is consumed directly by the IDLE decision
  logic                     r_abort;   // flush seen while a request is in flight
  logic [1:0][DATA_W-1:0]   r_rdata;

  logic w_inflight, w_lane, w_abort, w_to, w_ack;
  req_t w_cur;

  assign w_inflight = (r_state == L0) || (r_state == L1);
  assign w_lane     = (r_state == L1);
  assign w_cur      = r_req[w_lane];
  assign w_abort    = flash || r_abort;
  assign w_ack      = bus_ack || w_to;

  assign bus_req    = w_inflight;
  assign bus_we     = w_inflight & w_cur.we;
  assign bus_be     = w_inflight ? w_cur.be    : '0;
  assign bus_addr   = w_inflight ? w_cur.addr  : '0;
  assign bus_wdata  = w_inflight ? w_cur.wdata : '0;
  assign done       = (r_state == DONE);
  assign lane_rdata = r_rdata;
  assign stall_req  = !rst && (((r_state == IDLE) && |lane_valid && !flash) || w_inflight);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (!flash) begin
        if (lane_valid[0])      w_next = L0;
        else if (lane_valid[1]) w_next = L1;
      end
      L0:   if (w_ack) w_next = w_abort ? IDLE : (r_v1 ? L1 : DONE);
      L1:   if (w_ack) w_next = w_abort ? IDLE : DONE;
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_req   <= '0;
      r_v1    <= 1'b0;
      r_abort <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      if ((r_state == IDLE) && !flash) begin
        r_v1 <= lane_valid[1];
        for (int i = 0; i < 2; i++)
          r_req[i] <= '{we: lane_we[i], be: lane_be[i], addr: lane_addr[i], wdata: lane_wdata[i]};
      end
      if (w_next == IDLE)
        r_abort <= 1'b0;
      else if (w_inflight && flash)
        r_abort <= 1'b1;
      // A watchdog expiry completes a load with zero data; cancelled accesses leave rdata alone.
      if (w_inflight && w_ack && !w_abort && !w_cur.we)
        r_rdata[w_lane] <= bus_ack ? bus_rdata : '0;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_err;

  assign w_to     = w_inflight && !bus_ack && (r_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign lane_err = r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_err <= '0;
    end else begin
      if (w_next != r_state)
        r_cnt <= '0;
      else if (w_inflight && !bus_ack)
        r_cnt <= r_cnt + 1'b1;
      if (w_next == IDLE)
        r_err <= '0;
      else if (w_to)
        r_err[w_lane] <= 1'b1;
    end
  end
`else
  // Watchdog absent: the limit is only referenced so the parameter stays part of the interface.
  assign w_to     = 1'b0 && (TIMEOUT_CYCLES > 0);
  assign lane_err = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized transactions
// checked against a transaction-level model (issue order, stall length, load results).
module tb_mem_port_arbiter;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 1 << 30;
`endif

  logic              clk = 0;
  logic              rst, flash;
  logic [1:0]        lane_valid, lane_we;
  logic [1:0][3:0]   lane_be;
  logic [1:0][31:0]  lane_addr, lane_wdata;
  logic              stall_req, done, bus_req, bus_we, bus_ack;
  logic [1:0][31:0]  lane_rdata;
  logic [3:0]        bus_be;
  logic [31:0]       bus_addr, bus_wdata, bus_rdata;
  logic [1:0]        lane_err;

  int n_chk = 0;
  int n_err = 0;
  logic [1:0][31:0] exp_rd;
  logic [31:0]      rd_fix;

  mem_port_arbiter #(.TIMEOUT_CYCLES(4), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .flash(flash),
    .lane_valid(lane_valid), .lane_we(lane_we), .lane_be(lane_be),
    .lane_addr(lane_addr), .lane_wdata(lane_wdata),
    .stall_req(stall_req), .lane_rdata(lane_rdata), .done(done),
    .bus_req(bus_req), .bus_we(bus_we), .bus_be(bus_be), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .lane_err(lane_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1; flash = 0; lane_valid = 0; bus_ack = 0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_outs", 64'({stall_req, done, bus_req, bus_we, bus_be, lane_err}), 64'd0);
    chk("rst_bus", 64'({bus_addr, bus_wdata}), 64'd0);
    chk("rst_rdata", 64'(lane_rdata), 64'd0);
    @(posedge clk); #1;
    rst = 0;
    exp_rd = '0;
  endtask

  // One pipeline transaction; waits give the ack delay per lane (>= TO means never acked).
  task automatic run_txn(input logic [1:0] v, input logic [1:0] we, input logic [1:0][3:0] be,
                         input logic [1:0][31:0] ad, input logic [1:0][31:0] wd,
                         input int w0, input int w1, input string tag);
    int wt[2];
    int iss[2];
    int n_iss, k, c, l, stall_n, done_n, exp_stall;
    logic [1:0] exp_err;
    wt[0] = w0; wt[1] = w1;
    n_iss = 0; exp_stall = 0; exp_err = '0;
    for (int i = 0; i < 2; i++)
      if (v[i]) begin
        iss[n_iss] = i;
        n_iss++;
        exp_stall += (wt[i] >= TO) ? TO : wt[i] + 1;
      end
    if (n_iss > 0) exp_stall += 1;
    @(posedge clk); #1;
    lane_valid = v; lane_we = we; lane_be = be; lane_addr = ad; lane_wdata = wd; flash = 0;
    k = 0; c = 0; stall_n = 0; done_n = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      if (stall_req) stall_n++;
      if (done) begin
        done_n++;
        chk({tag, "_rdata0"}, 64'(lane_rdata[0]), 64'(exp_rd[0]));
        chk({tag, "_rdata1"}, 64'(lane_rdata[1]), 64'(exp_rd[1]));
        chk({tag, "_err"}, 64'(lane_err), 64'(exp_err));
      end
      bus_ack = 0;
      if (bus_req) begin
        if (k >= n_iss) chk({tag, "_extra_req"}, 64'd1, 64'd0);
        else begin
          l = iss[k];
          chk({tag, "_bus_ctl"}, 64'({bus_we, bus_be, bus_addr}), 64'({we[l], be[l], ad[l]}));
          chk({tag, "_bus_wdata"}, 64'(bus_wdata), 64'(wd[l]));
          if (wt[l] < TO) begin
            if (c == wt[l]) begin
              bus_ack = 1;
              bus_rdata = (rd_fix != 0) ? rd_fix : $urandom;
              if (!we[l]) exp_rd[l] = bus_rdata;
              k++; c = 0;
            end else c++;
          end else begin
            if (c == TO - 1) begin
              if (!we[l]) exp_rd[l] = '0;
              exp_err[l] = 1'b1;
              k++; c = 0;
            end else c++;
          end
        end
      end
      if (done || (n_iss == 0 && cyc == 2)) break;
    end
    lane_valid = 0;
    chk({tag, "_stall_cycles"}, 64'(stall_n), 64'(exp_stall));
    chk({tag, "_done_pulses"}, 64'(done_n), (n_iss > 0) ? 64'd1 : 64'd0);
    chk({tag, "_issued"}, 64'(k), 64'(n_iss));
    @(negedge clk);
    bus_ack = 0;
    chk({tag, "_post_idle"}, 64'({done, bus_req, stall_req, lane_err}), 64'd0);
  endtask

  initial begin
    rst = 1; flash = 0; lane_valid = 0; lane_we = 0; lane_be = 0;
    lane_addr = 0; lane_wdata = 0; bus_ack = 0; bus_rdata = 0; rd_fix = 0; exp_rd = '0;
    do_reset();

    rd_fix = 32'hDEADBEEF;
    run_txn(2'b01, 2'b00, {4'h0, 4'hF}, {32'h0, 32'h100}, {32'h0, 32'h0}, 0, 0, "one_lane");
    rd_fix = 0;
    run_txn(2'b11, 2'b01, {4'hF, 4'h3}, {32'h204, 32'h200}, {32'h0, 32'hCAFE0001}, 3, 3, "two_lane");
    run_txn(2'b10, 2'b00, {4'hC, 4'h1}, {32'h80, 32'h40}, {32'h0, 32'h0}, 0, 0, "lane1_only");
    run_txn(2'b00, 2'b00, {4'hF, 4'hF}, {32'h10, 32'h20}, {32'h0, 32'h0}, 0, 0, "no_lane");

    for (int t = 0; t < 40; t++)
      run_txn(2'($urandom), 2'($urandom), 8'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
`ifdef MEM_ARB_TIMEOUT_EN
              $urandom_range(0, 6), $urandom_range(0, 6),
`else
              $urandom_range(0, 3), $urandom_range(0, 3),
`endif
              "rand");

    // Flush while lane 0 waits: the access completes, lane 1 is dropped, no done.
    @(posedge clk); #1;
    lane_valid = 2'b11; lane_we = 0; lane_be = 8'hFF; lane_addr = {32'h44, 32'h40};
    @(negedge clk);
    chk("fl_idle_stall", 64'(stall_req), 64'd1);
    @(negedge clk);
    chk("fl_l0_req", 64'({bus_req, bus_addr}), 64'({1'b1, 32'h40}));
    flash = 1;
    @(posedge clk); #1;
    flash = 0;
    @(negedge clk);
    chk("fl_hold", 64'({bus_req, bus_addr}), 64'({1'b1, 32'h40}));
    bus_ack = 1; bus_rdata = 32'h5555; lane_valid = 0;
    @(negedge clk);
    chk("fl_idle_after", 64'({bus_req, done, stall_req}), 64'd0);
    bus_ack = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("fl_no_l1", 64'({bus_req, done}), 64'd0);
    end
    do_reset();

    // Flush in IDLE swallows the request.
    @(posedge clk); #1;
    lane_valid = 2'b01; flash = 1;
    @(negedge clk);
    chk("fi_stall", 64'(stall_req), 64'd0);
    @(posedge clk); #1;
    lane_valid = 0; flash = 0;
    @(negedge clk);
    chk("fi_no_req", 64'(bus_req), 64'd0);

    // Reset in the middle of lane 1.
    @(posedge clk); #1;
    lane_valid = 2'b11; lane_we = 0; lane_be = 8'hFF; lane_addr = {32'h304, 32'h300};
    @(negedge clk);
    @(negedge clk);
    bus_ack = 1; bus_rdata = 32'h1111;
    @(negedge clk);
    bus_ack = 0;
    chk("rst_l1_addr", 64'({bus_req, bus_addr}), 64'({1'b1, 32'h304}));
    rst = 1; lane_valid = 0;
    @(negedge clk);
    chk("rstm_outs", 64'({stall_req, done, bus_req, bus_we, bus_be, lane_err}), 64'd0);
    chk("rstm_addr", 64'(bus_addr), 64'd0);
    chk("rstm_rdata", 64'(lane_rdata), 64'd0);
    @(posedge clk); #1;
    rst = 0; exp_rd = '0;
    run_txn(2'b11, 2'b10, {4'h1, 4'h2}, {32'h404, 32'h400}, {32'h77, 32'h0}, 1, 0, "after_rst");

`ifdef MEM_ARB_TIMEOUT_EN
    run_txn(2'b01, 2'b00, {4'h0, 4'hF}, {32'h0, 32'h500}, {32'h0, 32'h0}, 100, 0, "timeout");
`else
    @(posedge clk); #1;
    lane_valid = 2'b01; lane_we = 0; lane_addr = {32'h0, 32'h500};
    repeat (20) @(negedge clk);
    chk("no_timeout_stall", 64'({stall_req, bus_req}), 64'd3);
    do_reset();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
